// File: rtl/regfile_dump.sv
// Debug read-out engine: walks a register-file read port and streams every register
// as a byte frame (HEADER, big-endian register data, XOR checksum) over valid/ready.
module regfile_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        start,
    output logic [4:0]  ctrl_readReg,
    input  logic [31:0] data_readReg,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    // state  | meaning
    // IDLE   | waiting for start
    // HDR    | offering the frame header byte
    // LOAD   | one cycle: snapshot the current register into the shift register
    // DATA   | offering the four bytes of the current register, MSB first
    // CSUM   | offering the XOR checksum of all data bytes
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_DATA,
        S_CSUM
    } state_t;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    state_t      state_q, state_d;
    logic [4:0]  reg_idx_q, reg_idx_d;
    logic [31:0] shift_q, shift_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic        done_q, done_d;

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q    <= S_IDLE;
            reg_idx_q  <= FIRST_IDX;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        reg_idx_d  = reg_idx_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        done_d     = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_HDR;
                    reg_idx_d = FIRST_IDX;
                    csum_d    = 8'h00;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d    = data_readReg;
                byte_cnt_d = 2'd0;
                state_d    = S_DATA;
            end
            S_DATA: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[31:24];
                if (tx_ready) begin
                    csum_d     = csum_q ^ shift_q[31:24];
                    shift_d    = {shift_q[23:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (reg_idx_q == LAST_IDX) begin
                            state_d = S_CSUM;
                        end else begin
                            reg_idx_d = reg_idx_q + 5'd1;
                            state_d   = S_LOAD;
                        end
                    end
                end
            end
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ctrl_readReg = reg_idx_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a frame-level byte model checked against two DUT instances
// (default range and a single-register range) on every cycle.
module tb_regfile_dump;

    typedef logic [7:0] bq_t[$];

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        ctrl_reset;
    logic        start_a, start_b, tx_ready;
    logic [4:0]  rr_a, rr_b;
    logic [31:0] rd_a, rd_b;
    logic [7:0]  txd_a, txd_b;
    logic        txv_a, txv_b, busy_a, busy_b, done_a, done_b;
    logic [31:0] rf [32];

    assign rd_a = rf[rr_a];
    assign rd_b = rf[rr_b];

    regfile_dump u_dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(start_a),
        .ctrl_readReg(rr_a), .data_readReg(rd_a),
        .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(tx_ready),
        .busy(busy_a), .done(done_a)
    );

    regfile_dump #(.FIRST_REG(5), .LAST_REG(5)) u_one (
        .clock(clock), .ctrl_reset(ctrl_reset), .start(start_b),
        .ctrl_readReg(rr_b), .data_readReg(rd_b),
        .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(tx_ready),
        .busy(busy_b), .done(done_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame = HEADER, each register MSB first, then XOR of all data bytes.
    function automatic bq_t build_frame(input int first, input int last, input logic [31:0] vals [32]);
        bq_t        q;
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        q.push_back(8'hA5);
        for (int r = first; r <= last; r++) begin
            for (int k = 3; k >= 0; k--) begin
                b = vals[r][8*k +: 8];
                cs ^= b;
                q.push_back(b);
            end
        end
        q.push_back(cs);
        return q;
    endfunction

    bq_t        exp_a, exp_b;
    logic       hold_a = 1'b0, hold_b = 1'b0;
    logic [7:0] held_a, held_b;
    int         busy_cyc_a = 0, busy_cyc_b = 0, done_cnt_a = 0, done_cnt_b = 0;

    always @(negedge clock) begin
        if (ctrl_reset) begin
            hold_a = 1'b0;
            hold_b = 1'b0;
        end else begin
            if (hold_a) begin
                chk("a_hold_valid", txv_a, 1'b1);
                chk("a_hold_data", txd_a, held_a);
            end
            if (txv_a && tx_ready) begin
                if (exp_a.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_extra_byte: got %0h expected no byte", txd_a);
                end else begin
                    chk("a_byte", txd_a, exp_a.pop_front());
                end
            end
            hold_a = txv_a && !tx_ready;
            held_a = txd_a;
            if (done_a) begin
                done_cnt_a++;
                chk("a_done_busy", busy_a, 1'b0);
            end
            if (busy_a) busy_cyc_a++;

            if (hold_b) begin
                chk("b_hold_valid", txv_b, 1'b1);
                chk("b_hold_data", txd_b, held_b);
            end
            if (txv_b && tx_ready) begin
                if (exp_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_extra_byte: got %0h expected no byte", txd_b);
                end else begin
                    chk("b_byte", txd_b, exp_b.pop_front());
                end
            end
            hold_b = txv_b && !tx_ready;
            held_b = txd_b;
            if (done_b) begin
                done_cnt_b++;
                chk("b_done_busy", busy_b, 1'b0);
            end
            if (busy_b) begin
                busy_cyc_b++;
                chk("b_readreg", rr_b, 5'd5);
            end
        end
    end

    int ready_mode = 0;
    int cyc = 0;
    always @(posedge clock) begin
        cyc++;
        #1;
        tx_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    task automatic pulse_start(input bit sel);
        @(posedge clock); #1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Leaves the caller at the negedge of the done cycle.
    task automatic wait_done(input bit sel, input int budget, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if ((sel ? done_b : done_a) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, got, 1'b1);
    endtask

    task automatic wait_state_a(input logic [4:0] idx, input logic want_valid, input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (rr_a == idx && busy_a && txv_a == want_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, got, 1'b1);
    endtask

    bq_t         frame, lit;
    logic [31:0] vals [32];
    int          bc0, dc0;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'hDEADBEEF;
        ctrl_reset = 1'b1;
        start_a    = 1'b0;
        start_b    = 1'b0;
        tx_ready   = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", txv_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_data", txd_a, 8'h00);
        chk("rst_readreg_a", rr_a, 5'd0);
        chk("rst_readreg_b", rr_b, 5'd5);
        ctrl_reset = 1'b0;

        frame = build_frame(0, 31, rf);
        chk("model_len", frame.size(), 130);
        chk("model_hdr", frame[0], 8'hA5);
        chk("model_reg0", frame[4], 8'h00);
        chk("model_reg1_msb", frame[5], 8'hDE);
        chk("model_csum", frame[129], 8'h22);

        // Single-register instance
        rf[5] = 32'h12345678;
        lit   = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        exp_b = build_frame(5, 5, rf);
        chk("model_one_len", exp_b.size(), 6);
        for (int i = 0; i < 6; i++) chk("model_one_byte", exp_b[i], lit[i]);
        bc0 = busy_cyc_b;
        dc0 = done_cnt_b;
        pulse_start(1'b1);
        wait_done(1'b1, 50, "one_done_timeout");
        @(posedge clock); #1;
        chk("one_busy_cycles", busy_cyc_b - bc0, 7);
        chk("one_done_count", done_cnt_b - dc0, 1);
        chk("one_bytes_left", exp_b.size(), 0);
        rf[5] = 32'hDEADBEEF;

        // Full default dump, ready always high
        exp_a = build_frame(0, 31, rf);
        bc0 = busy_cyc_a;
        dc0 = done_cnt_a;
        pulse_start(1'b0);
        @(negedge clock);
        chk("hdr_latency_valid", txv_a, 1'b1);
        chk("hdr_latency_data", txd_a, 8'hA5);
        wait_done(1'b0, 400, "full_done_timeout");
        @(posedge clock); #1;
        chk("full_busy_cycles", busy_cyc_a - bc0, 162);
        chk("full_done_count", done_cnt_a - dc0, 1);
        chk("full_bytes_left", exp_a.size(), 0);

        // Same dump with ready every third cycle
        ready_mode = 1;
        exp_a = build_frame(0, 31, rf);
        dc0 = done_cnt_a;
        pulse_start(1'b0);
        wait_done(1'b0, 1000, "slow_done_timeout");
        @(posedge clock); #1;
        chk("slow_done_count", done_cnt_a - dc0, 1);
        chk("slow_bytes_left", exp_a.size(), 0);
        ready_mode = 0;
        repeat (2) @(posedge clock);
        #1;

        // start while busy is ignored; start in the done cycle launches a new frame
        exp_a = build_frame(0, 31, rf);
        frame = build_frame(0, 31, rf);
        foreach (frame[i]) exp_a.push_back(frame[i]);
        dc0 = done_cnt_a;
        pulse_start(1'b0);
        repeat (20) @(posedge clock);
        #1;
        chk("mid_start_busy", busy_a, 1'b1);
        pulse_start(1'b0);
        wait_done(1'b0, 400, "b2b_done1_timeout");
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        @(negedge clock);
        chk("b2b_hdr_valid", txv_a, 1'b1);
        chk("b2b_hdr_data", txd_a, 8'hA5);
        wait_done(1'b0, 400, "b2b_done2_timeout");
        repeat (10) @(posedge clock);
        #1;
        chk("b2b_done_count", done_cnt_a - dc0, 2);
        chk("b2b_idle", busy_a, 1'b0);
        chk("b2b_bytes_left", exp_a.size(), 0);

        // Per-register snapshot: reg6 written after its LOAD, reg7 before its LOAD
        vals = rf;
        vals[7] = 32'h22222222;
        exp_a = build_frame(0, 31, vals);
        chk("model_reg6_msb", exp_a[25], 8'hDE);
        chk("model_reg7_msb", exp_a[29], 8'h22);
        dc0 = done_cnt_a;
        pulse_start(1'b0);
        wait_state_a(5'd6, 1'b0, "reg6_load_timeout");
        @(posedge clock); #1;
        rf[6] = 32'h11111111;
        rf[7] = 32'h22222222;
        wait_done(1'b0, 400, "coh_done_timeout");
        @(posedge clock); #1;
        chk("coh_done_count", done_cnt_a - dc0, 1);
        chk("coh_bytes_left", exp_a.size(), 0);
        rf[6] = 32'hDEADBEEF;
        rf[7] = 32'hDEADBEEF;

        // Asynchronous reset in the middle of reg10's data
        exp_a = build_frame(0, 31, rf);
        pulse_start(1'b0);
        wait_state_a(5'd10, 1'b1, "reg10_data_timeout");
        #2;
        ctrl_reset = 1'b1;
        #1;
        chk("arst_valid", txv_a, 1'b0);
        chk("arst_busy", busy_a, 1'b0);
        chk("arst_readreg", rr_a, 5'd0);
        chk("arst_data", txd_a, 8'h00);
        exp_a.delete();
        @(posedge clock); #1;
        ctrl_reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("arst_stays_idle", busy_a, 1'b0);
        exp_a = build_frame(0, 31, rf);
        dc0 = done_cnt_a;
        pulse_start(1'b0);
        wait_done(1'b0, 400, "arst_done_timeout");
        @(posedge clock); #1;
        chk("arst_done_count", done_cnt_a - dc0, 1);
        chk("arst_bytes_left", exp_a.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug read-out engine that walks the register file through one read port and streams every register's contents as a byte frame.
- The byte frame goes over a valid/ready byte interface to the board UART transmitter.
- Sits beside the processor's register file on the second read port. It is the consumer ("reader") counterpart to the register-file write path, used for post-mortem inspection without the LED tap.

Parameters:
- FIRST_REG, 0, first register index dumped (0..31).
- LAST_REG, 31, last register index dumped (0..31). Must satisfy FIRST_REG <= LAST_REG; illegal settings are unsupported.
- HEADER, 8'hA5, frame start byte.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- ctrl_reset  input  1  asynchronous, active-high reset.
- start  input  1  request one dump; sampled only in IDLE.
- ctrl_readReg  output  5  register index driven to the register-file read port.
- data_readReg  input  32  combinational read data for ctrl_readReg.
- tx_data  output  8  byte to transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter accepts byte.
- busy  output  1  dump in progress.
- done  output  1  one-cycle pulse after the checksum byte is accepted.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, tx_valid=0, tx_data=0, busy=0, done=0.
  - ctrl_readReg=FIRST_REG, checksum=0, byte counter=0.
  - Reset mid-frame abandons the frame with no further bytes; a later start begins a fresh frame at HEADER.
- Handshake:
  - A byte transfers on a rising edge where tx_valid && tx_ready.
  - While tx_valid=1 and no transfer has occurred, tx_data is held stable and tx_valid is not withdrawn.
  - tx_valid may be asserted before tx_ready.
- ctrl_readReg is registered; it always equals the current register index.
- FSM states:
  - IDLE: busy=0, tx_valid=0. start=1 at an edge -> HDR; reg_idx<=FIRST_REG; checksum<=0.
  - HDR: tx_valid=1, tx_data=HEADER. On transfer -> LOAD. HEADER is excluded from the checksum.
  - LOAD: exactly 1 cycle, tx_valid=0. Capture data_readReg (index = reg_idx) into a 32-bit shift register; byte_cnt<=0 -> DATA.
  - DATA: tx_valid=1, tx_data=shift[31:24], so each register is sent big-endian. On transfer:
    - checksum ^= tx_data; shift <<= 8; byte_cnt++.
    - On the transfer with byte_cnt==3: if reg_idx==LAST_REG -> CSUM, else reg_idx++ -> LOAD.
  - CSUM: tx_valid=1, tx_data=checksum (XOR of all data bytes). On transfer -> IDLE; done=1 for the following cycle.
- busy is 1 in every state except IDLE. The cycle done=1 has busy=0.
- A start received in the same cycle that done=1 begins a new frame; done and the HDR entry do not conflict.
- start asserted while busy is ignored, not queued.
- Frame length = 2 + 4*(LAST_REG-FIRST_REG+1) bytes. With defaults that is 130 bytes.
- Latency with tx_ready held at 1:
  - start edge N -> HEADER transfers at edge N+1.
  - Each register costs 5 cycles (LOAD + 4 DATA).
  - Full default dump: busy for 162 cycles; done appears in cycle 163.
- Coherence:
  - Each register is snapshotted at its own LOAD cycle. The dump is not an atomic image of the file.
  - A write to a register after its LOAD is not reflected. A write before its LOAD is.
- Register 0 is dumped as whatever the read port returns; the register file supplies 0.

Test Plan:
- FIRST_REG=LAST_REG=5, reg5=32'h12345678, tx_ready=1, pulse start -> bytes A5,12,34,56,78,08; busy high 7 cycles; single done pulse; ctrl_readReg=5 throughout.
- Defaults, regs1..31=32'hDEADBEEF, reg0=0, tx_ready=1 -> 130 bytes: A5, 00 00 00 00, then 31x DE AD BE EF, checksum 22; busy 162 cycles.
- Same dump with tx_ready high only every 3rd cycle -> identical byte sequence; tx_data/tx_valid never change while valid && !ready; checksum 22.
- Assert ctrl_reset asynchronously mid-DATA of reg 10 -> tx_valid and busy drop without a clock edge; new start yields a frame beginning A5 then reg FIRST_REG.
- Pulse start again during DATA, and in the done cycle -> first is ignored (one frame, one done); second starts a new frame with HDR next cycle.
- Write reg6 = 32'h11111111 in the cycle after reg6's LOAD, and write reg7 = 32'h22222222 before reg7's LOAD -> frame carries old reg6 value and new reg7 value.
